// File: rtl/lab_mult_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lab_mult_cell_arbiter
// Purpose  : Round-robin sharing of one 3-partial-product 16x16 multiplier cell
//            among NUM_REQ requesters; define MULT_CELL_ARB_HI_EN for rsp_hi.
// Revision : 1.0 - initial release
// ============================================================================
module lab_mult_cell_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_src1,
    input  logic [32*NUM_REQ-1:0]  req_src2,
    input  logic [NUM_REQ-1:0]     req_hi,
    output logic [31:0]            cell_src1,
    output logic [31:0]            cell_src2,
    output logic                   cell_en,
    input  logic [31:0]            cell_p1,
    input  logic [31:0]            cell_p2,
    input  logic [31:0]            cell_p3,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_lo,
    output logic [31:0]            rsp_hi
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_CAP_LO = 3'd2,
        S_CAP_HI = 3'd3,
        S_RSP    = 3'd4
    } state_t;

    localparam logic [ID_W:0]   c_num_req = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_last    = ID_W'(NUM_REQ - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_gnt_any;
    logic [ID_W:0]      w_cand;
    logic [NUM_REQ-1:0] w_ready;
    logic [31:0]        w_src1 [NUM_REQ];
    logic [31:0]        w_src2 [NUM_REQ];
    logic [31:0]        r_cell_src1;
    logic [31:0]        r_cell_src2;
    logic               r_cell_en;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_src1[gi] = req_src1[32*gi +: 32];
            assign w_src2[gi] = req_src2[32*gi +: 32];
        end
    endgenerate

`ifdef MULT_CELL_ARB_HI_EN
    logic        r_hi;
    logic [63:0] r_acc;
    logic [63:0] w_lo_sum;
    assign w_lo_sum = {32'h0, cell_p1} + {16'h0, cell_p2, 16'h0} + {16'h0, cell_p3, 16'h0};
    assign rsp_hi   = r_acc[63:32];
`else
    logic [31:0] r_acc;
    logic [31:0] w_lo_sum;
    logic        w_unused_bits;
    assign w_lo_sum      = cell_p1 + {cell_p2[15:0], 16'h0} + {cell_p3[15:0], 16'h0};
    assign rsp_hi        = '0;
    assign w_unused_bits = ^{req_hi, cell_p2[31:16], cell_p3[31:16]};
`endif

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (req_valid[w_cand[ID_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_any) begin
                    w_ready[w_gnt_idx] = 1'b1;
                    w_state_nxt        = S_ISSUE;
                end
            end
            S_ISSUE:  w_state_nxt = S_CAP_LO;
`ifdef MULT_CELL_ARB_HI_EN
            S_CAP_LO: w_state_nxt = r_hi ? S_CAP_HI : S_RSP;
`else
            S_CAP_LO: w_state_nxt = S_RSP;
`endif
            S_CAP_HI: w_state_nxt = S_RSP;
            S_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Cell operands are registered one state ahead so cell_en lines up with ISSUE/CAP_LO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_cell_src1 <= '0;
            r_cell_src2 <= '0;
            r_cell_en   <= 1'b0;
            r_acc       <= '0;
`ifdef MULT_CELL_ARB_HI_EN
            r_hi        <= 1'b0;
`endif
        end else begin
            r_cell_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_cell_src1 <= w_src1[w_gnt_idx];
                        r_cell_src2 <= w_src2[w_gnt_idx];
                        r_cell_en   <= 1'b1;
                        r_id        <= w_gnt_idx;
                        r_rr_ptr    <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
`ifdef MULT_CELL_ARB_HI_EN
                        r_hi        <= req_hi[w_gnt_idx];
`endif
                    end
                end
`ifdef MULT_CELL_ARB_HI_EN
                // The cell still holds the full operands, so shift them to get hi*hi.
                S_ISSUE: begin
                    if (r_hi) begin
                        r_cell_src1 <= {16'h0, r_cell_src1[31:16]};
                        r_cell_src2 <= {16'h0, r_cell_src2[31:16]};
                        r_cell_en   <= 1'b1;
                    end
                end
                S_CAP_LO: r_acc <= r_hi ? w_lo_sum : {32'h0, w_lo_sum[31:0]};
                S_CAP_HI: r_acc <= r_acc + {cell_p1, 32'h0};
`else
                S_CAP_LO: r_acc <= w_lo_sum;
`endif
                default: ;
            endcase
        end
    end

    assign req_ready = w_ready & {NUM_REQ{reset_n}};
    assign cell_src1 = r_cell_src1;
    assign cell_src2 = r_cell_src2;
    assign cell_en   = r_cell_en;
    assign rsp_valid = (r_state == S_RSP);
    assign rsp_id    = r_id;
    assign rsp_lo    = r_acc[31:0];

endmodule
`default_nettype wire

// File: tb/tb_lab_mult_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab_mult_cell_arbiter
// Purpose  : Self-checking bench for lab_mult_cell_arbiter with a behavioural
//            multiplier cell and a product/round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab_mult_cell_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_src1;
    logic [32*N-1:0] req_src2;
    logic [N-1:0]    req_hi;
    logic [31:0]     cell_src1, cell_src2, cell_p1, cell_p2, cell_p3;
    logic            cell_en;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_lo, rsp_hi;

    int total = 0;
    int bad   = 0;
    int rr    = 0;

    lab_mult_cell_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_hi    (req_hi),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_lo    (rsp_lo),
        .rsp_hi    (rsp_hi)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier cell: registers operands on cell_en.
    logic [31:0] ca = '0;
    logic [31:0] cb = '0;
    always @(posedge clk) begin
        if (cell_en) begin
            ca <= cell_src1;
            cb <= cell_src2;
        end
    end
    assign cell_p1 = {16'h0, ca[15:0]}  * {16'h0, cb[15:0]};
    assign cell_p2 = {16'h0, ca[15:0]}  * {16'h0, cb[31:16]};
    assign cell_p3 = {16'h0, ca[31:16]} * {16'h0, cb[15:0]};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic h);
        req_src1[32*i +: 32] = a;
        req_src2[32*i +: 32] = b;
        req_hi[i]            = h;
    endtask

    // One complete transaction: grant, compute, optional backpressure, handshake.
    task automatic do_txn(input int bp, input bit early, input bit hold,
                          input logic [N-1:0] glitch, input logic [N-1:0] late);
        int          g, n, lat, en_cnt, busy_gnt;
        logic [63:0] prod;
        logic        hi_eff;
        logic [N-1:0] exp_oh;
        logic [IW-1:0] s_id;
        logic [31:0] s_lo, s_hi;
        bit          stable;
        g = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(rr + k) % N]) g = (rr + k) % N;
        end
        exp_oh    = '0;
        exp_oh[g] = 1'b1;
        prod = {32'h0, req_src1[32*g +: 32]} * {32'h0, req_src2[32*g +: 32]};
`ifdef MULT_CELL_ARB_HI_EN
        hi_eff = req_hi[g];
`else
        hi_eff = 1'b0;
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready === '0 && n < 20);
        check("grant", req_ready, exp_oh);
        rr = (g + 1) % N;
        @(posedge clk);
        #1;
        if (!hold) req_valid[g] = 1'b0;
        if (early) rsp_ready = 1'b1;
        lat = 0;
        en_cnt = 0;
        busy_gnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (cell_en === 1'b1) en_cnt++;
            if (req_ready !== '0) busy_gnt++;
            if (lat == 1) req_valid = req_valid | glitch;
            if (lat == 2) req_valid = req_valid & ~glitch;
        end while (rsp_valid !== 1'b1 && lat < 12);
        check("latency", lat, hi_eff ? 4 : 3);
        check("cell_en_cycles", en_cnt, hi_eff ? 2 : 1);
        check("busy_grant", busy_gnt, 0);
        check("rsp_id", rsp_id, g);
        check("rsp_lo", rsp_lo, prod[31:0]);
        check("rsp_hi", rsp_hi, hi_eff ? prod[63:32] : 32'h0);
        if (!early && bp > 0) begin
            s_id = rsp_id;
            s_lo = rsp_lo;
            s_hi = rsp_hi;
            stable = 1'b1;
            req_valid = req_valid | late;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_lo !== s_lo ||
                    rsp_hi !== s_hi || req_ready !== '0) stable = 1'b0;
            end
            check("backpressure_stable", stable, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_release", rsp_valid, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_hi    = '0;
        req_src1  = '0;
        req_src2  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {req_ready, cell_en, rsp_valid, rsp_id, cell_src1, cell_src2}, '0);
        check("reset_rsp", {rsp_lo, rsp_hi}, '0);
        reset_n = 1'b1;

        // Single lo op from requester 0
        set_op(0, 32'h0001_2345, 32'h0006_789A, 1'b0);
        req_valid = 3'b001;
        do_txn(0, 1'b0, 1'b0, '0, '0);

        // Reset asserted mid CAP_LO; pointer must return to 0
        set_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        req_valid = 3'b001;
        @(negedge clk);
        check("rst_pre_grant", req_ready, 3'b001);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {req_ready, cell_en, rsp_valid, rsp_id, cell_src1, cell_src2}, '0);
        check("rst_mid_rsp", {rsp_lo, rsp_hi}, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rr = 0;
        set_op(1, 32'h0000_0003, 32'h0000_0005, 1'b0);
        req_valid = 3'b011;
        do_txn(0, 1'b0, 1'b0, '0, '0);
        req_valid = '0;

        // Full-width hi op
        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        req_valid = 3'b001;
        do_txn(0, 1'b0, 1'b0, '0, '0);

        // hi requested on 0xFFFF_FFFF * 2
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        req_valid = 3'b100;
        do_txn(0, 1'b0, 1'b0, '0, '0);

        // Round-robin with requesters 0 and 1 held valid
        set_op(0, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
        set_op(1, 32'h8000_0000, 32'h0000_0003, 1'b1);
        req_valid = 3'b011;
        for (int t = 0; t < 4; t++) do_txn(0, 1'b0, 1'b1, '0, '0);
        req_valid = '0;

        // Backpressure, a transient request while busy, a new request during RSP
        set_op(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        set_op(1, 32'h0000_0007, 32'h0000_0009, 1'b0);
        req_valid = 3'b001;
        do_txn(10, 1'b0, 1'b0, 3'b100, 3'b010);
        do_txn(0, 1'b0, 1'b0, '0, '0);
        req_valid = '0;

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            do_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, '0);
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
